spi_mem_ctrl: RTL and testbench
===============================

// Module: spi_mem_ctrl
// PURPOSE
//  Memory-side responder for the control FSM's mem_ctrl_op / mem_op_done handshake.
//  Serves instruction/constant reads from SPI flash (addr_sel = PC) and data reads/writes
//  to SPI RAM (addr_sel = MAR) over one shared SPI bus (mode 0) with two chip selects.
//  Sits between ctrl, the address registers and the data-bus mux (MUX_MEM input).
// PARAMETERS
//  DATA_BUS_WIDTH  8   data bus width; must be 8 (one SPI data byte per transfer)
//  ADDR_WIDTH      16  width of pc_addr/mar_addr; zero-extended to 24 SPI address bits
//  CLK_DIV         1   SPI half-period in clock cycles (>=1); SCLK = clock/(2*CLK_DIV)
// PORTS
//  clock        in   1               system clock
//  reset        in   1               asynchronous, active-high reset
//  mem_ctrl_op  in   mem_ctrl_op_e   MEM_NOP / MEM_READ / MEM_WRITE; 4th encoding = NOP
//  addr_sel     in   addr_sel_e      PC -> flash at pc_addr, MAR -> RAM at mar_addr
//  pc_addr      in   ADDR_WIDTH      program counter value
//  mar_addr     in   ADDR_WIDTH      memory address register value
//  data_in      in   DATA_BUS_WIDTH  write data (ALU THR output)
//  data_out     out  DATA_BUS_WIDTH  read data, to bus mux MUX_MEM input
//  mem_op_done  out  1               one-cycle completion pulse
//  spi_sclk     out  1               SPI clock, idle low
//  spi_mosi     out  1               SPI data out, MSB first
//  spi_miso     in   1               SPI data in
//  flash_cs_n   out  1               flash chip select, active low
//  ram_cs_n     out  1               RAM chip select, active low
// BEHAVIOUR
//  Reset: state IDLE; data_out=0, mem_op_done=0, spi_sclk=0, spi_mosi=0, both cs_n=1.
//   Reset mid-transfer aborts immediately (CS released); no done pulse.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: op != NOP accepted at edge E0; latch op, addr_sel, address and data_in.
//   Later input changes are ignored until DONE.
//  Frame (40 bits): cmd[7:0] (READ=0x03, WRITE=0x02), addr[23:0], data[7:0].
//   Write: data byte = latched data_in. Read: MOSI=0 during the data byte.
//  Timing: at E0 assert the selected cs_n and drive bit 39 on MOSI.
//   SCLK toggles every CLK_DIV cycles: rise at E0+(2k+1)*CLK_DIV, fall at E0+(2k+2)*CLK_DIV.
//   MISO is sampled on the rising edge; MOSI changes on the falling edge.
//  Completion: at E0+80*CLK_DIV, go to DONE: cs_n=1, sclk=0, mem_op_done=1 for exactly 1 cycle.
//   On reads, data_out takes the sampled byte at the same edge, so it is valid in the done cycle.
//  data_out holds its value until the next completed read; writes never change it.
//  DONE -> IDLE unconditionally. A request is accepted only from IDLE, so a new request
//   is seen no earlier than 1 cycle after the done pulse.
//   ctrl always presents NOP in that cycle.
//  MEM_WRITE with addr_sel=PC (flash is read-only): no SPI activity, both cs_n stay 1.
//   mem_op_done pulses in the cycle after E0.
//  Only one cs_n is low at any time; spi_sclk is low whenever both cs_n are high.
//  Address wrap: addresses above 2^ADDR_WIDTH-1 cannot occur; SPI addr[23:ADDR_WIDTH]=0.
// STRUCTURE
//  Shared package: mem_ctrl_op_e and addr_sel_e (existing); add SPI_CMD_READ=8'h03,
//   SPI_CMD_WRITE=8'h02 and SPI_FRAME_BITS=40.
//  Sub-module spi_shifter: CLK_DIV divider, 40-bit TX shift register, 8-bit RX shift
//   register, bit counter, busy/last flags.
//  spi_mem_ctrl keeps the FSM, request latch, CS select and data_out register.
// TESTING
//  1. READ, addr_sel=PC, pc_addr=0x1234, MISO model returns 0xA5, CLK_DIV=1:
//     flash_cs_n low; MOSI = 0x03,0x001234; done 80 cycles after E0; data_out=0xA5 in done cycle.
//  2. WRITE, addr_sel=MAR, mar_addr=0x00FF, data_in=0x3C:
//     ram_cs_n low; MOSI = 0x02,0x0000FF,0x3C; done at E0+80; data_out unchanged.
//  3. WRITE, addr_sel=PC: no SCLK edges, both cs_n stay 1; done pulses the cycle after E0.
//  4. CLK_DIV=3, RAM read returning 0x5A: done at E0+240; SCLK high/low for 3 cycles each;
//     done is a 1-cycle pulse; data_out=0x5A.
//  5. Assert reset 20 cycles into a read: cs_n=1, sclk=0, done never pulses;
//     data_out=0 after release; the next READ completes normally.
//  6. Change inputs mid-transfer (op->NOP, mar_addr->0xBEEF):
//     frame still carries the latched address; back-to-back requests are accepted
//     one cycle after done.

Source files
------------

// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and SPI flash/RAM protocol constants for the memory responder.
package spi_mem_ctrl_pkg;

  // The fourth encoding is not a real request and is treated exactly like MEM_NOP.
  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_ctrl_op_e;

  typedef enum logic {
    ADDR_PC  = 1'b0,
    ADDR_MAR = 1'b1
  } addr_sel_e;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         SPI_FRAME_BITS = 40;
  localparam int         SPI_ADDR_BITS  = 24;

endpackage

// File: rtl/spi_mem_ctrl_shifter.sv
// SPI mode-0 frame engine: divides the clock into SCLK, shifts a 40-bit frame out
// MSB first and collects the last 8 MISO bits sampled on rising SCLK.
module spi_mem_ctrl_shifter
  import spi_mem_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SPI_FRAME_BITS-1:0] frame,
  input  logic                      miso,
  output logic                      sclk,
  output logic                      mosi,
  output logic                      last,
  output logic [7:0]                rx_byte
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(SPI_FRAME_BITS);

  logic [DIV_W-1:0]          div_q, div_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sclk_q, sclk_d;
  logic                      busy_q, busy_d;
  logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
  logic [7:0]                rx_q, rx_d;
  logic                      tick;

  assign tick    = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
  // The falling edge after the 40th rise ends the frame.
  assign last    = tick && sclk_q && (cnt_q == CNT_W'(SPI_FRAME_BITS - 1));
  assign sclk    = sclk_q;
  assign mosi    = tx_q[SPI_FRAME_BITS-1];
  assign rx_byte = rx_q;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    busy_d = busy_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = '0;
      cnt_d  = '0;
      sclk_d = 1'b0;
      tx_d   = frame;
    end else if (busy_q) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = !sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[6:0], miso};
        end else if (last) begin
          busy_d = 1'b0;
          tx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
      tx_q   <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      tx_q   <= tx_d;
    end
  end

  // Receive bits are only consumed after a complete frame, so they need no reset.
  always_ff @(posedge clock) begin
    rx_q <= rx_d;
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory responder: turns mem_ctrl_op requests into SPI flash (PC) or SPI RAM (MAR)
// transfers on a shared bus and answers with a one-cycle mem_op_done pulse.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int CLK_DIV        = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  mem_ctrl_op_e              mem_ctrl_op,
  input  addr_sel_e                 addr_sel,
  input  logic [ADDR_WIDTH-1:0]     pc_addr,
  input  logic [ADDR_WIDTH-1:0]     mar_addr,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  output logic [DATA_BUS_WIDTH-1:0] data_out,
  output logic                      mem_op_done,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso,
  output logic                      flash_cs_n,
  output logic                      ram_cs_n
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e                    state_q, state_d;
  logic                      rd_q, rd_d;
  logic                      flash_cs_n_q, flash_cs_n_d;
  logic                      ram_cs_n_q, ram_cs_n_d;
  logic [DATA_BUS_WIDTH-1:0] data_out_q, data_out_d;

  logic                      is_req, flash_wr, start, last;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [7:0]                wr_byte, rx_byte;
  logic [SPI_FRAME_BITS-1:0] frame;

  assign is_req   = (mem_ctrl_op == MEM_READ) || (mem_ctrl_op == MEM_WRITE);
  // Flash is read-only: a write aimed at PC completes without touching the bus.
  assign flash_wr = (mem_ctrl_op == MEM_WRITE) && (addr_sel == ADDR_PC);
  assign req_addr = (addr_sel == ADDR_PC) ? pc_addr : mar_addr;
  assign wr_byte  = (mem_ctrl_op == MEM_WRITE) ? 8'(data_in) : 8'h00;
  assign frame    = {(mem_ctrl_op == MEM_WRITE) ? SPI_CMD_WRITE : SPI_CMD_READ,
                     SPI_ADDR_BITS'(req_addr), wr_byte};

  spi_mem_ctrl_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .frame   (frame),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .last    (last),
    .rx_byte (rx_byte)
  );

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    flash_cs_n_d = flash_cs_n_q;
    ram_cs_n_d   = ram_cs_n_q;
    data_out_d   = data_out_q;
    start        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_req) begin
          rd_d = (mem_ctrl_op == MEM_READ);
          if (flash_wr) begin
            state_d = ST_DONE;
          end else begin
            start        = 1'b1;
            state_d      = ST_SHIFT;
            flash_cs_n_d = (addr_sel != ADDR_PC);
            ram_cs_n_d   = (addr_sel == ADDR_PC);
          end
        end
      end
      ST_SHIFT: begin
        if (last) begin
          state_d      = ST_DONE;
          flash_cs_n_d = 1'b1;
          ram_cs_n_d   = 1'b1;
          if (rd_q) data_out_d = DATA_BUS_WIDTH'(rx_byte);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_q         <= 1'b0;
      flash_cs_n_q <= 1'b1;
      ram_cs_n_q   <= 1'b1;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      flash_cs_n_q <= flash_cs_n_d;
      ram_cs_n_q   <= ram_cs_n_d;
      data_out_q   <= data_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign mem_op_done = (state_q == ST_DONE);
  assign flash_cs_n  = flash_cs_n_q;
  assign ram_cs_n    = ram_cs_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl: two instances (CLK_DIV 1 and 3) talk to a
// behavioural SPI flash/RAM device; expected results come from a byte-array memory model.
module tb_spi_mem_ctrl;
  import spi_mem_ctrl_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  mem_ctrl_op_e op   [2];
  addr_sel_e    sel  [2];
  logic [15:0]  pc   [2];
  logic [15:0]  mar  [2];
  logic [7:0]   din  [2];
  logic [7:0]   dout [2];
  logic [1:0]   done, sclk, mosi, miso, fcs, rcs;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_mem_ctrl #(
      .DATA_BUS_WIDTH (8),
      .ADDR_WIDTH     (16),
      .CLK_DIV        ((g == 0) ? 1 : 3)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .mem_ctrl_op (op[g]),
      .addr_sel    (sel[g]),
      .pc_addr     (pc[g]),
      .mar_addr    (mar[g]),
      .data_in     (din[g]),
      .data_out    (dout[g]),
      .mem_op_done (done[g]),
      .spi_sclk    (sclk[g]),
      .spi_mosi    (mosi[g]),
      .spi_miso    (miso[g]),
      .flash_cs_n  (fcs[g]),
      .ram_cs_n    (rcs[g])
    );
  end

  typedef struct {
    int          inst;
    int          e0;
    int          lat;
    bit          has_frame;
    bit          flash;
    logic [39:0] frame;
    logic [7:0]  dout;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] ref_flash [0:65535];
  logic [7:0] ref_ram   [0:65535];
  logic [7:0] dev_flash [0:65535];
  logic [7:0] dev_ram   [0:65535];
  logic [7:0] last_rd   [2];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int cdiv(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Device model and monitor state
  int          nb [2], run [2];
  logic [39:0] sh [2], gframe [2];
  logic        which [2], gflash [2], got [2], pcs [2], psclk [2], pdone [2];
  logic [7:0]  rbyte [2];
  logic        cs_low;
  bit          dev_init = 1'b0;
  exp_t        em;

  always @(negedge clock) begin
    if (!dev_init) begin
      for (int a = 0; a < 65536; a++) begin
        dev_flash[a] = ref_flash[a];
        dev_ram[a]   = ref_ram[a];
      end
      dev_init = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        total++;
        if ({done[g], sclk[g], mosi[g], fcs[g], rcs[g]} != 5'b00011 || dout[g] != 8'h00) begin
          bad++;
          $display("FAIL reset_state[%0d]: got done=%b sclk=%b mosi=%b fcs=%b rcs=%b dout=%h, want 0 0 0 1 1 00",
                   g, done[g], sclk[g], mosi[g], fcs[g], rcs[g], dout[g]);
        end
        pcs[g] = 1'b0; psclk[g] = 1'b0; nb[g] = 0; pdone[g] = 1'b0; got[g] = 1'b0; miso[g] = 1'b0;
      end else begin
        cs_low = !fcs[g] || !rcs[g];
        total++;
        if ((!fcs[g] && !rcs[g]) || (fcs[g] && rcs[g] && sclk[g])) begin
          bad++;
          $display("FAIL bus_idle[%0d]: got fcs=%b rcs=%b sclk=%b", g, fcs[g], rcs[g], sclk[g]);
        end
        if (cs_low && !pcs[g]) begin
          nb[g] = 0; run[g] = 1; which[g] = !fcs[g]; sh[g] = '0;
        end else if (pcs[g]) begin
          if (sclk[g] != psclk[g]) begin
            total++;
            if (run[g] != cdiv(g)) begin
              bad++;
              $display("FAIL sclk_phase[%0d]: got %0d cycles, want %0d", g, run[g], cdiv(g));
            end
            run[g] = 1;
            if (sclk[g]) begin
              sh[g] = {sh[g][38:0], mosi[g]};
              nb[g]++;
            end else begin
              if (nb[g] == 32)
                rbyte[g] = (sh[g][31:24] == 8'h03) ?
                           (which[g] ? dev_flash[sh[g][15:0]] : dev_ram[sh[g][15:0]]) : 8'($urandom);
              miso[g] = (nb[g] >= 32 && nb[g] < 40) ? rbyte[g][39 - nb[g]] : 1'($urandom);
            end
          end else begin
            run[g]++;
          end
          if (!cs_low && nb[g] == 40) begin
            got[g] = 1'b1; gframe[g] = sh[g]; gflash[g] = which[g];
            if (sh[g][39:32] == 8'h02) begin
              if (which[g]) dev_flash[sh[g][23:8]] = sh[g][7:0];
              else          dev_ram[sh[g][23:8]]   = sh[g][7:0];
            end
          end
        end
        pcs[g] = cs_low; psclk[g] = sclk[g];

        if (done[g]) begin
          total++;
          if (pdone[g]) begin
            bad++;
            $display("FAIL done_width[%0d]: got done high 2 cycles, want 1", g);
          end
          if (sb_q.size() == 0 || sb_q[0].inst != g) begin
            bad++;
            $display("FAIL unexpected_done[%0d]: got done with no request pending", g);
          end else begin
            em = sb_q.pop_front();
            total++;
            if (cyc - em.e0 != em.lat) begin
              bad++;
              $display("FAIL latency[%0d]: got %0d cycles, want %0d", g, cyc - em.e0, em.lat);
            end
            total++;
            if (dout[g] !== em.dout) begin
              bad++;
              $display("FAIL data_out[%0d]: got %h want %h", g, dout[g], em.dout);
            end
            total++;
            if (em.has_frame) begin
              if (!got[g] || gframe[g] !== em.frame || gflash[g] != em.flash) begin
                bad++;
                $display("FAIL frame[%0d]: got seen=%b flash=%b frame=%h, want flash=%b frame=%h",
                         g, got[g], gflash[g], gframe[g], em.flash, em.frame);
              end
            end else if (got[g]) begin
              bad++;
              $display("FAIL no_bus[%0d]: got frame %h, want no SPI activity", g, gframe[g]);
            end
            got[g] = 1'b0;
          end
        end
        pdone[g] = done[g];
      end
    end
    if (sb_q.size() > 0 && (cyc - sb_q[0].e0) > sb_q[0].lat + 8) begin
      total++;
      bad++;
      $display("FAIL timeout[%0d]: got no done after %0d cycles, want %0d", sb_q[0].inst,
               cyc - sb_q[0].e0, sb_q[0].lat);
      void'(sb_q.pop_front());
    end
  end

  // Called at a negedge while the DUT is idle; returns in the idle cycle after done.
  task automatic issue(input int g, input mem_ctrl_op_e o, input addr_sel_e s,
                       input logic [15:0] p, input logic [15:0] m, input logic [7:0] d,
                       input logic [15:0] chg, input bit push);
    exp_t        e;
    logic [15:0] a;
    a = (s == ADDR_PC) ? p : m;
    op[g] = o; sel[g] = s; pc[g] = p; mar[g] = m; din[g] = d;
    e.inst      = g;
    e.e0        = cyc + 1;
    e.has_frame = !(o == MEM_WRITE && s == ADDR_PC);
    e.flash     = (s == ADDR_PC);
    e.lat       = e.has_frame ? 80 * cdiv(g) : 0;
    if (o == MEM_READ) begin
      last_rd[g] = (s == ADDR_PC) ? ref_flash[a] : ref_ram[a];
      e.frame    = {8'h03, 8'h00, a, 8'h00};
    end else begin
      if (s == ADDR_MAR) ref_ram[m] = d;
      e.frame = {8'h02, 8'h00, a, d};
    end
    e.dout = last_rd[g];
    if (push) sb_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    op[g] = MEM_NOP; sel[g] = addr_sel_e'($urandom_range(1, 0));
    pc[g] = 16'($urandom); mar[g] = chg; din[g] = 8'($urandom);
    if (push) begin
      for (int i = 0; i < e.lat + 20; i++) begin
        if (done[g]) break;
        @(negedge clock);
      end
      @(negedge clock);
    end
  endtask

  int r, gap, gi;

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      op[g] = MEM_NOP; sel[g] = ADDR_PC; pc[g] = '0; mar[g] = '0; din[g] = '0; last_rd[g] = 8'h00;
    end
    for (int a = 0; a < 65536; a++) begin
      ref_flash[a] = 8'($urandom);
      ref_ram[a]   = 8'($urandom);
    end
    ref_flash[16'h1234] = 8'hA5;
    ref_ram[16'h0042]   = 8'h5A;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    issue(0, MEM_READ,  ADDR_PC,  16'h1234, 16'h7777, 8'h11, 16'h0000, 1'b1);
    issue(0, MEM_WRITE, ADDR_MAR, 16'h4321, 16'h00FF, 8'h3C, 16'h1111, 1'b1);
    issue(0, MEM_WRITE, ADDR_PC,  16'h0100, 16'h0200, 8'h99, 16'h2222, 1'b1);
    issue(1, MEM_READ,  ADDR_MAR, 16'h0300, 16'h0042, 8'h00, 16'h3333, 1'b1);

    // Abort a read 20 cycles in; no done may appear, data_out clears.
    issue(0, MEM_READ, ADDR_MAR, 16'h0000, 16'h0042, 8'h00, 16'h4444, 1'b0);
    repeat (19) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    for (int g = 0; g < 2; g++) last_rd[g] = 8'h00;
    repeat (100) @(negedge clock);
    issue(0, MEM_READ, ADDR_PC, 16'h1234, 16'h0000, 8'h00, 16'h5555, 1'b1);

    // Inputs change mid-transfer; requests follow back-to-back.
    issue(0, MEM_READ,  ADDR_MAR, 16'h0000, 16'h00FF, 8'h00, 16'hBEEF, 1'b1);
    issue(0, MEM_WRITE, ADDR_MAR, 16'h0000, 16'hBEEF, 8'hC3, 16'h00FF, 1'b1);
    issue(0, MEM_READ,  ADDR_MAR, 16'h0000, 16'hBEEF, 8'h00, 16'h0000, 1'b1);

    for (int t = 0; t < 72; t++) begin
      gi  = (t % 9 == 8) ? 1 : 0;
      r   = $urandom_range(9, 0);
      gap = $urandom_range(3, 0);
      for (int k = 0; k < gap; k++) begin
        op[gi] = ($urandom_range(1, 0) == 0) ? MEM_NOP : MEM_RSVD;
        pc[gi] = 16'($urandom); mar[gi] = 16'($urandom);
        @(negedge clock);
      end
      if (r < 3)
        issue(gi, MEM_READ,  ADDR_PC,  16'($urandom), 16'($urandom), 8'($urandom), 16'($urandom), 1'b1);
      else if (r < 6)
        issue(gi, MEM_READ,  ADDR_MAR, 16'($urandom), 16'($urandom_range(15, 0)), 8'($urandom),
              16'($urandom), 1'b1);
      else if (r < 9)
        issue(gi, MEM_WRITE, ADDR_MAR, 16'($urandom), 16'($urandom_range(15, 0)), 8'($urandom),
              16'($urandom), 1'b1);
      else
        issue(gi, MEM_WRITE, ADDR_PC,  16'($urandom), 16'($urandom), 8'($urandom), 16'($urandom), 1'b1);
    end

    repeat (300) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
